// File: rtl/m4_ccm_pkg.sv
// m4_ccm_pkg: shared defaults, coefficient address map and identity preset for the colour matrix
package m4_ccm_pkg;
  localparam int DW_DEF = 16;
  localparam int CW_DEF = 14;
  localparam int FRAC_DEF = 11;
  localparam int N_CF = 9;
  localparam logic [3:0] A_OFF_R = 4'd9;
  localparam logic [3:0] A_OFF_G = 4'd10;
  localparam logic [3:0] A_OFF_B = 4'd11;
  localparam int LAT = 3;
  function automatic int ident_cf(input int idx, input int frac);
    return (idx % 4 == 0 && idx < N_CF) ? (1 << frac) : 0;
  endfunction
endpackage

// File: rtl/m4_ccm_dot3.sv
// m4_ccm_dot3: one matrix row -- three signed products, rounded sum, offset and clamp to pixel range
module m4_ccm_dot3 #(
  parameter int DW = 16,
  parameter int CW = 14,
  parameter int FRAC = 11
) (
  input  logic                 clk,
  input  logic signed [CW-1:0] c0,
  input  logic signed [CW-1:0] c1,
  input  logic signed [CW-1:0] c2,
  input  logic signed [CW-1:0] off,
  input  logic [DW-1:0]        r,
  input  logic [DW-1:0]        g,
  input  logic [DW-1:0]        b,
  output logic [DW-1:0]        y,
  output logic                 sat
);
  localparam int PW = DW + CW + 1;
  localparam int SW = DW + CW + 3;
  localparam int VW = SW + 1;
  localparam logic signed [SW-1:0] RND = SW'(1) << (FRAC - 1);
  logic signed [PW-1:0] p0, p1, p2;
  logic signed [SW-1:0] s;
  logic signed [CW-1:0] off1, off2;
  logic signed [VW-1:0] v;
  logic hi;
  function automatic logic signed [PW-1:0] mul(input logic signed [CW-1:0] c, input logic [DW-1:0] x);
    return PW'(c) * PW'($signed({1'b0, x}));
  endfunction
  always_ff @(posedge clk) begin
    p0 <= mul(c0, r);
    p1 <= mul(c1, g);
    p2 <= mul(c2, b);
    off1 <= off;
    s <= SW'(p0) + SW'(p1) + SW'(p2) + RND;
    off2 <= off1;
  end
  // sign bit flags underflow; any set bit above DW (while positive) flags overflow
  assign v = VW'(s >>> FRAC) + VW'(off2);
  assign hi = |v[VW-2:DW];
  assign sat = v[VW-1] | hi;
  assign y = v[VW-1] ? '0 : hi ? '1 : v[DW-1:0];
endmodule

// File: rtl/m4_ccm_param.sv
// m4_ccm_param: 3x3 colour correction matrix with frame-synchronous shadow commit,
// 3-cycle pipeline, bypass and per-frame clamp counter.
module m4_ccm_param
  import m4_ccm_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3*DW-1:0]      pix_in,
  input  logic                 valid_in,
  input  logic                 cf_we,
  input  logic [3:0]           cf_addr,
  input  logic signed [CW-1:0] cf_data,
  input  logic                 m4_on,
  input  logic                 ovp,
  output logic [3*DW-1:0]      pix_out,
  output logic                 valid_out,
  output logic [15:0]          sat_cnt
);
  logic signed [CW-1:0] sh_cf [N_CF];
  logic signed [CW-1:0] act_cf [N_CF];
  logic signed [CW-1:0] sh_off [3];
  logic signed [CW-1:0] act_off [3];
  logic sh_en, act_en, v1, v2, en1, en2;
  logic [3*DW-1:0] px1, px2, y;
  logic [2:0] sat;
  logic [1:0] inc;
  logic [16:0] acc;
  // commit copies the pre-write shadow because both updates are non-blocking
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N_CF; i++) begin
        sh_cf[i] <= CW'(ident_cf(i, FRAC));
        act_cf[i] <= CW'(ident_cf(i, FRAC));
      end
      for (int i = 0; i < 3; i++) begin
        sh_off[i] <= '0;
        act_off[i] <= '0;
      end
      sh_en <= 1'b0;
      act_en <= 1'b0;
    end else begin
      sh_en <= m4_on;
      if (cf_we && cf_addr < 4'(N_CF)) sh_cf[cf_addr] <= cf_data;
      if (cf_we && cf_addr >= A_OFF_R && cf_addr <= A_OFF_B) sh_off[2'(cf_addr - A_OFF_R)] <= cf_data;
      if (ovp) begin
        act_cf <= sh_cf;
        act_off <= sh_off;
        act_en <= sh_en;
      end
    end
  for (genvar k = 0; k < 3; k++) begin : g_row
    m4_ccm_dot3 #(.DW(DW), .CW(CW), .FRAC(FRAC)) u_dot (
      .clk(clk),
      .c0(act_cf[3*k]),
      .c1(act_cf[3*k+1]),
      .c2(act_cf[3*k+2]),
      .off(act_off[k]),
      .r(pix_in[DW-1:0]),
      .g(pix_in[2*DW-1:DW]),
      .b(pix_in[3*DW-1:2*DW]),
      .y(y[k*DW +: DW]),
      .sat(sat[k])
    );
  end
  assign inc = (v2 && en2) ? 2'(sat[0]) + 2'(sat[1]) + 2'(sat[2]) : 2'd0;
  assign acc = (ovp ? 17'd0 : {1'b0, sat_cnt}) + 17'(inc);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      en1 <= 1'b0;
      en2 <= 1'b0;
      px1 <= '0;
      px2 <= '0;
      valid_out <= 1'b0;
      pix_out <= '0;
      sat_cnt <= '0;
    end else begin
      v1 <= valid_in;
      v2 <= v1;
      en1 <= act_en;
      en2 <= en1;
      px1 <= pix_in;
      px2 <= px1;
      valid_out <= v2;
      if (v2) pix_out <= en2 ? y : px2;
      sat_cnt <= acc[16] ? '1 : acc[15:0];
    end
endmodule

// File: tb/tb_m4_ccm_param.sv
// tb_m4_ccm_param: directed table of single-pixel matrix vectors plus hand sequences
// for clamp counting, reset, shadow commit timing and bypass streaming.
module tb_m4_ccm_param;
  logic clk = 0, rst_n = 0, valid_in = 0, cf_we = 0, m4_on = 0, ovp = 0;
  logic [47:0] pix_in = '0;
  logic [3:0] cf_addr = '0;
  logic signed [13:0] cf_data = '0;
  logic [47:0] pix_out;
  logic valid_out;
  logic [15:0] sat_cnt;
  int pass = 0, total = 0;

  typedef struct {
    logic signed [13:0] c0, c1, c2, off;
    logic en;
    logic [47:0] p, e;
    logic [15:0] s;
  } vec_t;
  vec_t tv[12];

  m4_ccm_param dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .valid_in(valid_in), .cf_we(cf_we),
    .cf_addr(cf_addr), .cf_data(cf_data), .m4_on(m4_on), .ovp(ovp),
    .pix_out(pix_out), .valid_out(valid_out), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] px(input int r, input int g, input int b);
    return {16'(b), 16'(g), 16'(r)};
  endfunction
  function automatic vec_t mk(input int c0, c1, c2, off, en, input logic [47:0] p, e, input int s);
    vec_t v;
    v.c0 = 14'(c0); v.c1 = 14'(c1); v.c2 = 14'(c2); v.off = 14'(off);
    v.en = en[0]; v.p = p; v.e = e; v.s = 16'(s);
    return v;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [3:0] a, input int d);
    cf_we = 1; cf_addr = a; cf_data = 14'(d);
    tick();
    cf_we = 0;
  endtask
  task automatic commit();
    ovp = 1;
    tick();
    ovp = 0;
  endtask
  task automatic run1(input string nm, input logic [47:0] p, input logic [47:0] e);
    pix_in = p; valid_in = 1;
    tick();
    valid_in = 0;
    tick();
    tick();
    chk(nm, {15'd0, valid_out, pix_out}, {16'd1, e});
  endtask

  initial begin
    logic [47:0] sp [40];
    logic sv [40];
    logic [47:0] last;
    logic have_last;
    int seen;
    tv[0]  = mk(2048, 0, 0, 0, 1, px(1000, 2000, 3000), px(1000, 2000, 3000), 0);
    tv[1]  = mk(8191, 0, 0, 0, 1, px(65535, 0, 0), px(65535, 0, 0), 1);
    tv[2]  = mk(-2048, 0, 0, 0, 1, px(100, 5, 7), px(0, 5, 7), 1);
    tv[3]  = mk(1024, 0, 0, 0, 1, px(3, 0, 0), px(2, 0, 0), 0);
    tv[4]  = mk(1024, 0, 0, -5, 1, px(3, 0, 0), px(0, 0, 0), 1);
    tv[5]  = mk(2048, 2048, 2048, 0, 1, px(30000, 30000, 30000), px(65535, 30000, 30000), 1);
    tv[6]  = mk(0, -1024, 1024, 100, 1, px(0, 1000, 3000), px(1100, 1000, 3000), 0);
    tv[7]  = mk(-1024, 0, 0, 10, 1, px(5, 0, 0), px(8, 0, 0), 0);
    tv[8]  = mk(2048, 0, 0, 8191, 1, px(60000, 0, 0), px(65535, 0, 0), 1);
    tv[9]  = mk(1023, 0, 0, 0, 1, px(3, 0, 0), px(1, 0, 0), 0);
    tv[10] = mk(4096, -2048, 0, 0, 1, px(100, 150, 0), px(50, 150, 0), 0);
    tv[11] = mk(8191, 0, 0, 0, 0, px(65535, 1, 2), px(65535, 1, 2), 0);

    tick();
    tick();
    chk("rst_pix", pix_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_sat", sat_cnt, 0);
    rst_n = 1;
    tick();

    foreach (tv[i]) begin
      m4_on = tv[i].en;
      wr(0, tv[i].c0);
      wr(1, tv[i].c1);
      wr(2, tv[i].c2);
      wr(9, tv[i].off);
      commit();
      pix_in = tv[i].p; valid_in = 1;
      tick();
      valid_in = 0;
      tick();
      chk($sformatf("v%0d_early", i), valid_out, 0);
      tick();
      chk($sformatf("v%0d_pix", i), {15'd0, valid_out, pix_out}, {16'd1, tv[i].e});
      chk($sformatf("v%0d_sat", i), sat_cnt, tv[i].s);
    end

    // all three rows clamp: count accumulates by 3, then OVP restarts with the same-cycle clamps
    m4_on = 1;
    wr(0, 8191); wr(4, 8191); wr(8, 8191); wr(9, 0);
    commit();
    pix_in = px(65535, 65535, 65535); valid_in = 1;
    tick();
    tick();
    valid_in = 0;
    tick();
    chk("sat3", sat_cnt, 3);
    chk("sat3_pix", pix_out, px(65535, 65535, 65535));
    tick();
    chk("sat6", sat_cnt, 6);
    valid_in = 1;
    tick();
    valid_in = 0;
    tick();
    ovp = 1;
    tick();
    ovp = 0;
    chk("ovp_clamp", sat_cnt, 3);
    valid_in = 1;
    for (int i = 0; i < 21846; i++) tick();
    valid_in = 0;
    tick(); tick(); tick();
    chk("sat_max", sat_cnt, 16'hffff);

    // reset with valid output in flight
    valid_in = 1; pix_in = px(7, 8, 9);
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_valid", valid_out, 1);
    #2;
    rst_n = 0; valid_in = 0;
    #1;
    chk("async_valid", valid_out, 0);
    chk("async_pix", pix_out, 0);
    chk("async_sat", sat_cnt, 0);
    tick();
    tick();
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid_out) seen++;
    end
    chk("no_ghost", seen, 0);
    m4_on = 1;
    tick();
    commit();
    run1("post_rst_ident", px(1000, 2000, 3000), px(1000, 2000, 3000));
    chk("post_rst_sat", sat_cnt, 0);

    // shadow vs active timing
    wr(0, 1024);
    run1("no_commit", px(2000, 0, 0), px(2000, 0, 0));
    pix_in = px(2000, 0, 0); valid_in = 1; ovp = 1;
    tick();
    ovp = 0;
    tick();
    valid_in = 0;
    tick();
    chk("inflight_old", pix_out, px(2000, 0, 0));
    tick();
    chk("after_commit", pix_out, px(1000, 0, 0));
    cf_we = 1; cf_addr = 0; cf_data = 512; ovp = 1;
    tick();
    cf_we = 0; ovp = 0;
    run1("we_ovp_old", px(2000, 0, 0), px(1000, 0, 0));
    commit();
    run1("we_ovp_next", px(2000, 0, 0), px(500, 0, 0));

    // bypass stream with random gaps; output is input delayed, held across bubbles
    m4_on = 0;
    tick();
    commit();
    have_last = 0;
    last = '0;
    for (int i = 0; i < 42; i++) begin
      if (i < 40) begin
        sv[i] = ($urandom_range(0, 3) != 0);
        sp[i] = {$urandom(), $urandom()};
        valid_in = sv[i];
        pix_in = sp[i];
      end else valid_in = 0;
      tick();
      if (i >= 2) begin
        chk($sformatf("byp_v%0d", i), valid_out, sv[i-2]);
        if (sv[i-2]) begin
          last = sp[i-2];
          have_last = 1;
        end
        if (have_last) chk($sformatf("byp_p%0d", i), pix_out, last);
      end
    end
    chk("byp_sat", sat_cnt, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
